rtc_bus_arbiter: RTL and testbench
==================================

// Module: rtc_bus_arbiter
// PURPOSE
// Shares the multiplexed address/data bus of the external RTC between three requesters:
// init sequencer, write sequencer and read-scan sequencer (0x21-0x28, 0x41-0x43).
// Fixed-priority grant, then one timed bus cycle: address phase, gap, data phase, recovery.
// Sits between the sequencers and the FPGA pin drivers. The bidirectional pad is instantiated at top level.
// PARAMETERS
// PHASE_CYC  8'd8  clocks per bus phase; legal 1..255; 0 is illegal
// PORTS
// clk        in   1  system clock
// reset      in   1  asynchronous, active-high reset
// req        in   3  [2]=init(write) [1]=write [0]=read; level, held until matching done
// addr_init  in   8  register address, init port
// wdata_init in   8  write data, init port
// addr_wr    in   8  register address, write port
// wdata_wr   in   8  write data, write port
// addr_rd    in   8  register address, read port
// grant      out  3  one-hot; owner of the current transaction
// done       out  3  one-cycle pulse per port on completion
// rdata      out  8  last read data; valid from done[0] until next read completes
// busy       out  1  high whenever not IDLE
// cs_n       out  1  RTC chip select
// rd_n       out  1  RTC read strobe
// wr_n       out  1  RTC write strobe
// ad_sel     out  1  0=address phase, 1=data phase
// ad_out     out  8  bus drive value
// ad_oe      out  1  1=FPGA drives bus
// ad_in      in   8  bus sample value
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, cs_n=rd_n=wr_n=1, ad_sel=0, ad_oe=0, ad_out=0.
//   Also grant=0, done=0, rdata=0, busy=0, phase counter=0. Strobes rise asynchronously.
// - All outputs are registered.
// - FSM: IDLE -> ADDR -> GAP -> DATA -> RECOV -> IDLE. Each non-IDLE state lasts exactly PHASE_CYC clocks.
// - IDLE: sample req; highest set bit wins (init > write > read). Latch addr/wdata/rnw of the winner.
//   Next cycle: ADDR, with grant one-hot set. No arbitration outside IDLE; no preemption.
// - ADDR: cs_n=0, ad_sel=0, ad_oe=1, ad_out=addr, wr_n=0.
// - GAP: cs_n=0, ad_sel=1, wr_n=rd_n=1. ad_oe=1 with ad_out=wdata for writes; ad_oe=0 for reads.
// - DATA write: wr_n=0, ad_oe=1, ad_out=wdata.
// - DATA read: rd_n=0, ad_oe=0. ad_in is captured into rdata on the last DATA clock.
// - RECOV: cs_n=1, all strobes=1, ad_oe=0; grant held.
// - Return to IDLE: grant=0. done[owner]=1 for the first IDLE cycle only.
//   Arbitration is suppressed in that cycle. Each requester drops req on seeing its done.
// - Latency: req sampled in cycle 0 -> done at cycle 4*PHASE_CYC+1.
//   Minimum spacing between grants is 4*PHASE_CYC+2 clocks.
// - req dropped mid-transaction: the cycle completes and done still pulses. Held addr/wdata changes are ignored.
// - Simultaneous requests: lower-priority requests wait. A pending read is served only when init and write are both idle.
// - Phase counter: 8-bit, counts 1..PHASE_CYC, then reloads 1 on state change; no wrap beyond PHASE_CYC.
// - ad_oe and rd_n are never both active: rd_n falls only in DATA of a read, after ad_oe has been 0 for all of GAP.
// STRUCTURE
// - Package rtc_bus_pkg: state encoding (IDLE, ADDR, GAP, DATA, RECOV) and port indices (P_INIT=2, P_WR=1, P_RD=0).
// - Sub-module rtc_phase_timer: load/count/terminal-count pulse, width 8, parameter PHASE_CYC.
// - Top: arbiter, request latch, FSM, registered pin outputs.
// TESTING
// 1 Read 0x21, PHASE_CYC=8, ad_in=8'h59 in DATA -> ADDR: ad_out=21, wr_n=0 for 8 clks.
//   Then rd_n=0 for 8 clks; done[0] at cycle 33; rdata=8'h59.
// 2 req=3'b111 in one cycle -> grant sequence init, write, read.
//   done order [2],[1],[0]; read starts 34 clks after write grant.
// 3 Write addr 0x41, wdata 0x12 -> ad_sel=1 and ad_out=12 through GAP and DATA; wr_n=0 only in ADDR and DATA; ad_oe never 0 before RECOV.
// 4 Assert reset in 3rd DATA clock of a read -> cs_n=rd_n=1 asynchronously; grant=0, rdata=0.
//   No done pulse; a fresh read after release completes normally.
// 5 PHASE_CYC=1, read req held high -> back-to-back transactions every 6 clks; done[0] each 6th clk.
// 6 Drop req[1] during GAP of a write -> DATA still strobes wr_n; done[1] pulses once; no second grant.

Source files
------------

// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC bus arbiter: bus-cycle state encoding and requester port indices.
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_GAP   = 3'd2,
        ST_DATA  = 3'd3,
        ST_RECOV = 3'd4
    } state_t;

    localparam int P_INIT = 2;
    localparam int P_WR   = 1;
    localparam int P_RD   = 0;

endpackage

// File: rtl/rtc_phase_timer.sv
// Phase timer: counts 1..PHASE_CYC within a bus phase, flags the last clock of the phase.
module rtc_phase_timer #(
    parameter logic [7:0] PHASE_CYC = 8'd8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_clr,
    output logic o_tc
);

    logic [7:0] r_cnt;

    // Saturates at PHASE_CYC; the FSM always reloads or clears on the terminal clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 8'd0;
        end else if (i_clr) begin
            r_cnt <= 8'd0;
        end else if (i_load) begin
            r_cnt <= 8'd1;
        end else if (r_cnt != PHASE_CYC) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_tc = (r_cnt == PHASE_CYC);

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Fixed-priority arbiter for the multiplexed RTC address/data bus; runs one timed bus cycle per grant.
// state | meaning: IDLE arbitrate (skipped on done cycle) | ADDR address+wr_n | GAP turnaround | DATA strobe | RECOV release
module rtc_bus_arbiter
    import rtc_bus_pkg::*;
#(
    parameter logic [7:0] PHASE_CYC = 8'd8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic [7:0] addr_init,
    input  logic [7:0] wdata_init,
    input  logic [7:0] addr_wr,
    input  logic [7:0] wdata_wr,
    input  logic [7:0] addr_rd,
    output logic [2:0] grant,
    output logic [2:0] done,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad_sel,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in
);

    state_t     r_state, w_state_nxt;
    logic       r_rnw, w_rnw;
    logic [7:0] r_addr, w_addr;
    logic [7:0] r_wdata, w_wdata;
    logic [2:0] r_grant, w_grant;
    logic [2:0] r_done, w_done;
    logic [7:0] r_rdata, w_rdata;
    logic       r_busy, w_busy;
    logic       r_cs_n, w_cs_n;
    logic       r_rd_n, w_rd_n;
    logic       r_wr_n, w_wr_n;
    logic       r_ad_sel, w_ad_sel;
    logic [7:0] r_ad_out, w_ad_out;
    logic       r_ad_oe, w_ad_oe;
    logic       w_load, w_clr, w_tc;

    rtc_phase_timer #(.PHASE_CYC(PHASE_CYC)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load),
        .i_clr  (w_clr),
        .o_tc   (w_tc)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_rnw       = r_rnw;
        w_addr      = r_addr;
        w_wdata     = r_wdata;
        w_grant     = r_grant;
        w_done      = 3'b000;
        w_rdata     = r_rdata;
        w_load      = 1'b0;
        w_clr       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_grant = 3'b000;
                // The done cycle is never an arbitration cycle, so a held req cannot be re-granted early.
                if (r_done == 3'b000 && req != 3'b000) begin
                    w_state_nxt = ST_ADDR;
                    w_load      = 1'b1;
                    if (req[P_INIT]) begin
                        w_grant[P_INIT] = 1'b1;
                        w_rnw           = 1'b0;
                        w_addr          = addr_init;
                        w_wdata         = wdata_init;
                    end else if (req[P_WR]) begin
                        w_grant[P_WR] = 1'b1;
                        w_rnw         = 1'b0;
                        w_addr        = addr_wr;
                        w_wdata       = wdata_wr;
                    end else begin
                        w_grant[P_RD] = 1'b1;
                        w_rnw         = 1'b1;
                        w_addr        = addr_rd;
                        w_wdata       = 8'h00;
                    end
                end else begin
                    w_clr = 1'b1;
                end
            end
            ST_ADDR: if (w_tc) begin
                w_state_nxt = ST_GAP;
                w_load      = 1'b1;
            end
            ST_GAP: if (w_tc) begin
                w_state_nxt = ST_DATA;
                w_load      = 1'b1;
            end
            ST_DATA: if (w_tc) begin
                w_state_nxt = ST_RECOV;
                w_load      = 1'b1;
                if (r_rnw) begin
                    w_rdata = ad_in;
                end
            end
            ST_RECOV: if (w_tc) begin
                w_state_nxt = ST_IDLE;
                w_clr       = 1'b1;
                w_done      = r_grant;
                w_grant     = 3'b000;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant     = 3'b000;
                w_clr       = 1'b1;
            end
        endcase

        // Pin values are decoded from the next state so they register together with it.
        w_busy   = (w_state_nxt != ST_IDLE);
        w_cs_n   = 1'b1;
        w_rd_n   = 1'b1;
        w_wr_n   = 1'b1;
        w_ad_sel = 1'b0;
        w_ad_oe  = 1'b0;
        w_ad_out = 8'h00;
        case (w_state_nxt)
            ST_ADDR: begin
                w_cs_n   = 1'b0;
                w_wr_n   = 1'b0;
                w_ad_oe  = 1'b1;
                w_ad_out = w_addr;
            end
            ST_GAP: begin
                w_cs_n   = 1'b0;
                w_ad_sel = 1'b1;
                w_ad_oe  = ~w_rnw;
                w_ad_out = w_rnw ? 8'h00 : w_wdata;
            end
            ST_DATA: begin
                w_cs_n   = 1'b0;
                w_ad_sel = 1'b1;
                if (w_rnw) begin
                    w_rd_n = 1'b0;
                end else begin
                    w_wr_n   = 1'b0;
                    w_ad_oe  = 1'b1;
                    w_ad_out = w_wdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_rnw    <= 1'b0;
            r_addr   <= 8'h00;
            r_wdata  <= 8'h00;
            r_grant  <= 3'b000;
            r_done   <= 3'b000;
            r_rdata  <= 8'h00;
            r_busy   <= 1'b0;
            r_cs_n   <= 1'b1;
            r_rd_n   <= 1'b1;
            r_wr_n   <= 1'b1;
            r_ad_sel <= 1'b0;
            r_ad_out <= 8'h00;
            r_ad_oe  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rnw    <= w_rnw;
            r_addr   <= w_addr;
            r_wdata  <= w_wdata;
            r_grant  <= w_grant;
            r_done   <= w_done;
            r_rdata  <= w_rdata;
            r_busy   <= w_busy;
            r_cs_n   <= w_cs_n;
            r_rd_n   <= w_rd_n;
            r_wr_n   <= w_wr_n;
            r_ad_sel <= w_ad_sel;
            r_ad_out <= w_ad_out;
            r_ad_oe  <= w_ad_oe;
        end
    end

    assign grant  = r_grant;
    assign done   = r_done;
    assign rdata  = r_rdata;
    assign busy   = r_busy;
    assign cs_n   = r_cs_n;
    assign rd_n   = r_rd_n;
    assign wr_n   = r_wr_n;
    assign ad_sel = r_ad_sel;
    assign ad_out = r_ad_out;
    assign ad_oe  = r_ad_oe;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Scoreboard bench for rtc_bus_arbiter: one instance with PHASE_CYC=8, one with PHASE_CYC=1.
module tb_rtc_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    // PHASE_CYC = 8 instance
    logic       reset8;
    logic [2:0] req8;
    logic [7:0] addr_init8, wdata_init8, addr_wr8, wdata_wr8, addr_rd8, ad_in8;
    logic [2:0] grant8, done8;
    logic [7:0] rdata8, ad_out8;
    logic       busy8, cs_n8, rd_n8, wr_n8, ad_sel8, ad_oe8;

    // PHASE_CYC = 1 instance
    logic       reset1;
    logic [2:0] req1;
    logic [7:0] addr_init1, wdata_init1, addr_wr1, wdata_wr1, addr_rd1, ad_in1;
    logic [2:0] grant1, done1;
    logic [7:0] rdata1, ad_out1;
    logic       busy1, cs_n1, rd_n1, wr_n1, ad_sel1, ad_oe1;

    rtc_bus_arbiter #(.PHASE_CYC(8'd8)) dut8 (
        .clk(clk), .reset(reset8), .req(req8),
        .addr_init(addr_init8), .wdata_init(wdata_init8),
        .addr_wr(addr_wr8), .wdata_wr(wdata_wr8), .addr_rd(addr_rd8),
        .grant(grant8), .done(done8), .rdata(rdata8), .busy(busy8),
        .cs_n(cs_n8), .rd_n(rd_n8), .wr_n(wr_n8), .ad_sel(ad_sel8),
        .ad_out(ad_out8), .ad_oe(ad_oe8), .ad_in(ad_in8)
    );

    rtc_bus_arbiter #(.PHASE_CYC(8'd1)) dut1 (
        .clk(clk), .reset(reset1), .req(req1),
        .addr_init(addr_init1), .wdata_init(wdata_init1),
        .addr_wr(addr_wr1), .wdata_wr(wdata_wr1), .addr_rd(addr_rd1),
        .grant(grant1), .done(done1), .rdata(rdata1), .busy(busy1),
        .cs_n(cs_n1), .rd_n(rd_n1), .wr_n(wr_n1), .ad_sel(ad_sel1),
        .ad_out(ad_out1), .ad_oe(ad_oe1), .ad_in(ad_in1)
    );

    typedef struct {
        logic [2:0] done;
        int         at;
        bit         is_rd;
        logic [7:0] rdata;
    } exp_t;

    exp_t q8[$];
    exp_t q1[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitors: every done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!reset8) begin
            chk("oe_rd_excl8", 32'(ad_oe8 & ~rd_n8), 32'd0);
            if (done8 != 3'b000) begin
                if (q8.size() == 0) begin
                    chk("done8_unexpected", 32'(done8), 32'd0);
                end else begin
                    e = q8.pop_front();
                    chk("done8_port", 32'(done8), 32'(e.done));
                    chk("done8_cycle", 32'(cyc), 32'(e.at));
                    if (e.is_rd) chk("rdata8", 32'(rdata8), 32'(e.rdata));
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset1 && done1 != 3'b000) begin
            if (q1.size() == 0) begin
                chk("done1_unexpected", 32'(done1), 32'd0);
            end else begin
                e = q1.pop_front();
                chk("done1_port", 32'(done1), 32'(e.done));
                chk("done1_cycle", 32'(cyc), 32'(e.at));
                if (e.is_rd) chk("rdata1", 32'(rdata1), 32'(e.rdata));
            end
        end
    end

    // Expected pins for cycle t after the request (t=1 is the first ADDR clock), PHASE_CYC=8.
    task automatic chk_pins8(input string tag, input int t, input bit rnw,
                             input logic [2:0] gnt, input logic [7:0] a, input logic [7:0] d);
        int ph;
        logic [3:0] e_ctl;
        ph = (t - 1) / 8;
        case (ph)
            0:       e_ctl = 4'b0101;
            1:       e_ctl = {3'b011, ~rnw};
            2:       e_ctl = rnw ? 4'b0010 : 4'b0101;
            default: e_ctl = 4'b1110;
        endcase
        chk({tag, "_ctl"}, 32'({cs_n8, rd_n8, wr_n8, ad_oe8}), 32'(e_ctl));
        if (ph <= 2) chk({tag, "_ad_sel"}, 32'(ad_sel8), 32'(ph != 0));
        if (e_ctl[0]) chk({tag, "_ad_out"}, 32'(ad_out8), 32'(ph == 0 ? a : d));
        chk({tag, "_grant"}, 32'(grant8), 32'(ph < 4 ? gnt : 3'b000));
        chk({tag, "_busy"}, 32'(busy8), 32'(ph < 4));
    endtask

    // One full transaction on dut8; requester inputs are scrambled after latching.
    task automatic txn8(input string tag, input int port, input logic [7:0] a,
                        input logic [7:0] d, input int drop_at);
        int c0;
        int t;
        bit rnw;
        logic [2:0] g;
        rnw = (port == 0);
        g = 3'b001 << port;
        c0 = cyc;
        case (port)
            2:       begin addr_init8 = a; wdata_init8 = d; end
            1:       begin addr_wr8 = a; wdata_wr8 = d; end
            default: addr_rd8 = a;
        endcase
        ad_in8 = 8'hAA;
        q8.push_back('{g, c0 + 33, rnw, 8'h59});
        req8 = g;
        for (int k = 0; k < 33; k++) begin
            @(negedge clk);
            t = cyc - c0;
            chk_pins8(tag, t, rnw, g, a, d);
            if (t == 2) begin
                addr_init8 = 8'hFF; wdata_init8 = 8'hFF;
                addr_wr8 = 8'hFF; wdata_wr8 = 8'hFF; addr_rd8 = 8'hFF;
            end
            if (t == 17) ad_in8 = 8'h33;
            if (t == 24) ad_in8 = 8'h59;
            if (t == 25) ad_in8 = 8'hEE;
            if (t == drop_at) req8 = 3'b000;
        end
        req8 = 3'b000;
        @(negedge clk);
        chk({tag, "_post_grant"}, 32'(grant8), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int t;
        reset8 = 1'b1; reset1 = 1'b1;
        req8 = 3'b000; req1 = 3'b000;
        addr_init8 = 8'h00; wdata_init8 = 8'h00; addr_wr8 = 8'h00; wdata_wr8 = 8'h00;
        addr_rd8 = 8'h00; ad_in8 = 8'h00;
        addr_init1 = 8'h00; wdata_init1 = 8'h00; addr_wr1 = 8'h00; wdata_wr1 = 8'h00;
        addr_rd1 = 8'h00; ad_in1 = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset8_state", 32'({grant8, done8, busy8, cs_n8, rd_n8, wr_n8, ad_sel8, ad_oe8, ad_out8, rdata8}),
            32'({3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00}));
        chk("reset1_state", 32'({grant1, done1, busy1, cs_n1, rd_n1, wr_n1, ad_sel1, ad_oe1, ad_out1, rdata1}),
            32'({3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00}));
        reset8 = 1'b0; reset1 = 1'b0;
        @(negedge clk);

        // Read 0x21, write 0x41/0x12, init write, write with req dropped in GAP
        txn8("t1_rd21", 0, 8'h21, 8'h00, 33);
        txn8("t3_wr41", 1, 8'h41, 8'h12, 33);
        txn8("init_wr", 2, 8'h2A, 8'h5C, 33);
        txn8("t6_drop", 1, 8'h43, 8'h99, 10);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t6_no_regrant", 32'({grant8, busy8}), 32'd0);
        end

        // All three requests in the same cycle
        c0 = cyc;
        addr_init8 = 8'h28; wdata_init8 = 8'h01;
        addr_wr8 = 8'h42; wdata_wr8 = 8'h02;
        addr_rd8 = 8'h26; ad_in8 = 8'h7C;
        q8.push_back('{3'b100, c0 + 33, 1'b0, 8'h00});
        q8.push_back('{3'b010, c0 + 67, 1'b0, 8'h00});
        q8.push_back('{3'b001, c0 + 101, 1'b1, 8'h7C});
        req8 = 3'b111;
        for (int k = 0; k < 101; k++) begin
            @(negedge clk);
            t = cyc - c0;
            if (t == 1)  chk("t2_grant_init", 32'(grant8), 32'h4);
            if (t == 35) chk("t2_grant_wr", 32'(grant8), 32'h2);
            if (t == 69) chk("t2_grant_rd", 32'(grant8), 32'h1);
            if (t == 34) chk("t2_gap_idle", 32'(grant8), 32'h0);
            if (t == 33)  req8[2] = 1'b0;
            if (t == 67)  req8[1] = 1'b0;
            if (t == 101) req8[0] = 1'b0;
        end
        @(negedge clk);

        // Reset during the 3rd DATA clock of a read
        addr_rd8 = 8'h22; ad_in8 = 8'h11;
        req8 = 3'b001;
        repeat (19) @(negedge clk);
        chk("t4_rd_active", 32'({cs_n8, rd_n8}), 32'd0);
        #1 reset8 = 1'b1;
        #1;
        chk("t4_async_pins", 32'({cs_n8, rd_n8, wr_n8, ad_oe8}), 32'b1110);
        chk("t4_async_regs", 32'({grant8, rdata8, busy8}), 32'd0);
        req8 = 3'b000;
        repeat (3) @(negedge clk);
        reset8 = 1'b0;
        @(negedge clk);
        txn8("t4_fresh", 0, 8'h28, 8'h00, 33);

        // PHASE_CYC=1, read request held high
        c0 = cyc;
        addr_rd1 = 8'h25; ad_in1 = 8'h3C;
        for (int k = 0; k < 4; k++) q1.push_back('{3'b001, c0 + 5 + 6 * k, 1'b1, 8'h3C});
        req1 = 3'b001;
        for (int k = 0; k < 23; k++) begin
            @(negedge clk);
            t = cyc - c0;
            chk("t5_oe_rd_excl", 32'(ad_oe1 & ~rd_n1), 32'd0);
            if ((t - 1) % 6 == 0) chk("t5_addr_grant", 32'({grant1, cs_n1, wr_n1}), 32'b00100);
            if ((t - 5) % 6 == 0) chk("t5_done_idle", 32'({grant1, busy1}), 32'd0);
            if (t == 23) req1 = 3'b000;
        end
        repeat (10) @(negedge clk);
        chk("t5_idle_after", 32'({grant1, busy1}), 32'd0);

        chk("q8_drained", 32'(q8.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
